// File: rtl/rtc_core.sv
// Real-time clock core: 24-hour BCD timekeeping with a clock-cycle prescaler,
// validated loads and a 12/24-hour display mapping.
module rtc_core #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst,
  input  logic        rtc_en,
  input  logic        rtc_mode12,
  input  logic        rtc_set,
  input  logic [23:0] rtc_set_bcd,
  output logic [23:0] rtc_bcd,
  output logic        rtc_pm,
  output logic        rtc_sec_tick,
  output logic        rtc_day_tick,
  output logic        rtc_set_err
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic [3:0] n_h1, n_h0, n_m1, n_m0, n_s1, n_s0;
  logic       day_wrap;

  logic [3:0] set_h1, set_h0, set_m1, set_m0, set_s1, set_s0;
  logic       set_valid;
  logic       load;
  logic       wrap;
  logic       advance;

  logic [4:0] hour_bin;
  logic [4:0] hr12;
  logic [3:0] disp_h1, disp_h0;

  assign set_h1 = rtc_set_bcd[23:20];
  assign set_h0 = rtc_set_bcd[19:16];
  assign set_m1 = rtc_set_bcd[15:12];
  assign set_m0 = rtc_set_bcd[11:8];
  assign set_s1 = rtc_set_bcd[7:4];
  assign set_s0 = rtc_set_bcd[3:0];

  // Load value must be a legal 24-hour time in BCD
  always_comb begin
    set_valid = (set_h0 <= 4'd9) && (set_m0 <= 4'd9) && (set_s0 <= 4'd9) &&
                (set_m1 <= 4'd5) && (set_s1 <= 4'd5) &&
                ((set_h1 < 4'd2) || ((set_h1 == 4'd2) && (set_h0 <= 4'd3)));
  end

  assign load    = rtc_set && set_valid;
  assign wrap    = rtc_en && (pre == PRE_MAX);
  assign advance = wrap && !load;

  // Next time one second on, with BCD digit carries and midnight wrap
  always_comb begin
    n_h1     = h1;
    n_h0     = h0;
    n_m1     = m1;
    n_m0     = m0;
    n_s1     = s1;
    n_s0     = s0;
    day_wrap = 1'b0;
    if (s0 != 4'd9) begin
      n_s0 = s0 + 4'd1;
    end else begin
      n_s0 = 4'd0;
      if (s1 != 4'd5) begin
        n_s1 = s1 + 4'd1;
      end else begin
        n_s1 = 4'd0;
        if (m0 != 4'd9) begin
          n_m0 = m0 + 4'd1;
        end else begin
          n_m0 = 4'd0;
          if (m1 != 4'd5) begin
            n_m1 = m1 + 4'd1;
          end else begin
            n_m1 = 4'd0;
            if ((h1 == 4'd2) && (h0 == 4'd3)) begin
              n_h1     = 4'd0;
              n_h0     = 4'd0;
              day_wrap = 1'b1;
            end else if (h0 == 4'd9) begin
              n_h1 = h1 + 4'd1;
              n_h0 = 4'd0;
            end else begin
              n_h0 = h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Prescaler, time registers and strobe outputs; a valid load beats an advance
  always_ff @(posedge rtc_clk or posedge rtc_rst) begin
    if (rtc_rst) begin
      pre          <= '0;
      h1           <= 4'd0;
      h0           <= 4'd0;
      m1           <= 4'd0;
      m0           <= 4'd0;
      s1           <= 4'd0;
      s0           <= 4'd0;
      rtc_sec_tick <= 1'b0;
      rtc_day_tick <= 1'b0;
      rtc_set_err  <= 1'b0;
    end else begin
      rtc_sec_tick <= advance;
      rtc_day_tick <= advance && day_wrap;
      rtc_set_err  <= rtc_set && !set_valid;
      if (load) begin
        pre <= '0;
        h1  <= set_h1;
        h0  <= set_h0;
        m1  <= set_m1;
        m0  <= set_m0;
        s1  <= set_s1;
        s0  <= set_s0;
      end else if (rtc_en) begin
        pre <= wrap ? '0 : pre + PW'(1);
        if (wrap) begin
          h1 <= n_h1;
          h0 <= n_h0;
          m1 <= n_m1;
          m0 <= n_m0;
          s1 <= n_s1;
          s0 <= n_s0;
        end
      end
    end
  end

  assign hour_bin = 5'(h1) * 5'd10 + 5'(h0);

  // Display hour mapping; 12-hour mode shows 00 as 12 and folds 13..23 down
  always_comb begin
    disp_h1 = h1;
    disp_h0 = h0;
    hr12    = hour_bin;
    if (rtc_mode12) begin
      if (hour_bin == 5'd0) begin
        hr12 = 5'd12;
      end else if (hour_bin > 5'd12) begin
        hr12 = hour_bin - 5'd12;
      end
      if (hr12 >= 5'd10) begin
        disp_h1 = 4'd1;
        disp_h0 = 4'(hr12 - 5'd10);
      end else begin
        disp_h1 = 4'd0;
        disp_h0 = 4'(hr12);
      end
    end
  end

  assign rtc_bcd = {disp_h1, disp_h0, m1, m0, s1, s0};
  assign rtc_pm  = (hour_bin >= 5'd12);

endmodule

// File: tb/tb_rtc_core.sv
// Scoreboarded bench for rtc_core: a seconds-of-day reference model predicts
// each cycle's outputs; a negedge monitor pops and compares.
module tb_rtc_core;

  localparam int HZ = 4;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst;
  logic        rtc_en;
  logic        rtc_mode12;
  logic        rtc_set;
  logic [23:0] rtc_set_bcd;
  logic [23:0] rtc_bcd;
  logic        rtc_pm;
  logic        rtc_sec_tick;
  logic        rtc_day_tick;
  logic        rtc_set_err;

  rtc_core #(.CLK_HZ(HZ)) dut (
    .rtc_clk      (rtc_clk),
    .rtc_rst      (rtc_rst),
    .rtc_en       (rtc_en),
    .rtc_mode12   (rtc_mode12),
    .rtc_set      (rtc_set),
    .rtc_set_bcd  (rtc_set_bcd),
    .rtc_bcd      (rtc_bcd),
    .rtc_pm       (rtc_pm),
    .rtc_sec_tick (rtc_sec_tick),
    .rtc_day_tick (rtc_day_tick),
    .rtc_set_err  (rtc_set_err)
  );

  always #5 rtc_clk = ~rtc_clk;

  typedef struct {
    int sod;
    bit tick;
    bit day;
    bit err;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   sod   = 0;
  int   pre   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit valid_bcd(input logic [23:0] v);
    int h;
    if (v[19:16] > 9 || v[11:8] > 9 || v[3:0] > 9 || v[23:20] > 9) return 1'b0;
    if (v[15:12] > 5 || v[7:4] > 5) return 1'b0;
    h = int'(v[23:20]) * 10 + int'(v[19:16]);
    return h <= 23;
  endfunction

  function automatic int bcd_to_sod(input logic [23:0] v);
    int h, m, s;
    h = int'(v[23:20]) * 10 + int'(v[19:16]);
    m = int'(v[15:12]) * 10 + int'(v[11:8]);
    s = int'(v[7:4]) * 10 + int'(v[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] disp(input int t, input bit m12);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    if (m12) begin
      if (h == 0) h = 12;
      else if (h > 12) h = h - 12;
    end
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] rand_valid();
    int h, m, s;
    if ($urandom_range(0, 3) == 0) begin
      h = 23; m = 59; s = int'($urandom_range(50, 59));
    end else begin
      h = int'($urandom_range(0, 23));
      m = int'($urandom_range(0, 59));
      s = int'($urandom_range(0, 59));
    end
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // One clock edge: apply inputs, step the reference model, queue the expectation
  task automatic cycle(input bit en, input bit set, input logic [23:0] v, input bit m12);
    rec_t r;
    rtc_en      = en;
    rtc_set     = set;
    rtc_set_bcd = v;
    rtc_mode12  = m12;
    @(posedge rtc_clk);
    r.tick = 1'b0;
    r.day  = 1'b0;
    r.err  = 1'b0;
    if (set && valid_bcd(v)) begin
      sod = bcd_to_sod(v);
      pre = 0;
    end else begin
      r.err = set;
      if (en) begin
        if (pre == HZ - 1) begin
          pre    = 0;
          r.tick = 1'b1;
          r.day  = (sod == 86399);
          sod    = (sod + 1) % 86400;
        end else begin
          pre++;
        end
      end
    end
    r.sod = sod;
    q.push_back(r);
    #1;
    rtc_set = 1'b0;
  endtask

  // Reset asserted between edges; outputs must settle before any clock edge
  task automatic do_reset();
    rtc_rst = 1'b1;
    q.delete();
    sod = 0;
    pre = 0;
    #1;
    rtc_mode12 = 1'b0;
    #1;
    check("rst_bcd24", rtc_bcd, 24'h000000);
    check("rst_pm", rtc_pm, 1'b0);
    check("rst_sec_tick", rtc_sec_tick, 1'b0);
    check("rst_day_tick", rtc_day_tick, 1'b0);
    check("rst_set_err", rtc_set_err, 1'b0);
    rtc_mode12 = 1'b1;
    #1;
    check("rst_bcd12", rtc_bcd, 24'h120000);
    check("rst_pm12", rtc_pm, 1'b0);
    repeat (2) @(posedge rtc_clk);
    #1;
    rtc_rst    = 1'b0;
    rtc_mode12 = 1'b0;
  endtask

  // Monitor: compare every post-edge output set against the queued prediction
  initial begin
    rec_t r;
    forever begin
      @(negedge rtc_clk);
      if (!rtc_rst && q.size() > 0) begin
        r = q.pop_front();
        check("mon_bcd", rtc_bcd, disp(r.sod, rtc_mode12));
        check("mon_pm", rtc_pm, (r.sod / 3600) >= 12);
        check("mon_sec_tick", rtc_sec_tick, r.tick);
        check("mon_day_tick", rtc_day_tick, r.day);
        check("mon_set_err", rtc_set_err, r.err);
      end
    end
  end

  initial begin
    rtc_rst     = 1'b1;
    rtc_en      = 1'b0;
    rtc_mode12  = 1'b0;
    rtc_set     = 1'b0;
    rtc_set_bcd = 24'h0;
    do_reset();

    // First second after reset
    repeat (4) cycle(1, 0, 24'h0, 0);
    check("first_tick", rtc_sec_tick, 1'b1);
    check("first_bcd", rtc_bcd, 24'h000001);

    // Midnight wrap
    cycle(1, 1, 24'h235958, 0);
    repeat (8) cycle(1, 0, 24'h0, 0);
    check("midnight_bcd", rtc_bcd, 24'h000000);
    check("midnight_day", rtc_day_tick, 1'b1);

    // Rejected loads, then a PM load shown in 12-hour mode
    cycle(0, 1, 24'h245000, 0);
    check("err_245000", rtc_set_err, 1'b1);
    cycle(0, 1, 24'h126000, 0);
    check("err_126000", rtc_set_err, 1'b1);
    cycle(0, 1, 24'h12A000, 0);
    check("err_12A000", rtc_set_err, 1'b1);
    cycle(0, 1, 24'h130000, 1);
    check("pm_bcd12", rtc_bcd, 24'h010000);
    check("pm_flag", rtc_pm, 1'b1);

    // Load on the advance edge wins
    while (pre != HZ - 1) cycle(1, 0, 24'h0, 0);
    cycle(1, 1, 24'h083000, 0);
    check("load_adv_tick", rtc_sec_tick, 1'b0);
    check("load_adv_bcd", rtc_bcd, 24'h083000);
    repeat (4) cycle(1, 0, 24'h0, 0);
    check("load_adv_next", rtc_bcd, 24'h083001);

    // Enable hold at prescaler 2
    while (pre != 2) cycle(1, 0, 24'h0, 0);
    repeat (10) cycle(0, 0, 24'h0, 0);
    cycle(1, 0, 24'h0, 0);
    check("hold_no_tick", rtc_sec_tick, 1'b0);
    cycle(1, 0, 24'h0, 0);
    check("hold_tick", rtc_sec_tick, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit          en, st, m12;
      logic [23:0] v;
      en  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 15) == 0);
      m12 = $urandom_range(0, 1) == 1;
      v   = ($urandom_range(0, 1) == 1) ? rand_valid() : 24'($urandom);
      cycle(en, st, v, m12);
    end

    // Full hour sweep in 12-hour mode
    for (int h = 0; h < 24; h++) begin
      logic [23:0] v;
      v = {4'(h / 10), 4'(h % 10), 16'h0000};
      cycle(0, 1, v, 1);
      check("sweep_bcd12", rtc_bcd, disp(h * 3600, 1'b1));
      check("sweep_pm", rtc_pm, h >= 12);
    end

    // Asynchronous reset right after a tick at 10:59:59
    cycle(0, 1, 24'h105958, 0);
    repeat (4) cycle(1, 0, 24'h0, 0);
    check("pre_rst_bcd", rtc_bcd, 24'h105959);
    check("pre_rst_tick", rtc_sec_tick, 1'b1);
    #1;
    do_reset();
    repeat (3) cycle(1, 0, 24'h0, 0);
    check("post_rst_no_tick", rtc_sec_tick, 1'b0);
    cycle(1, 0, 24'h0, 0);
    check("post_rst_tick", rtc_bcd, 24'h000001);

    cycle(0, 0, 24'h0, 0);
    @(negedge rtc_clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
